// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU arbiter slice.
// Optional zero flag output is enabled by ALU_ARB_ZERO_FLAG_EN.
package alu_arb_pkg;

  localparam int ALU_W  = 8;
  localparam int CTRL_W = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of alu_arbiter.
// rsp_zero_o exists only when ALU_ARB_ZERO_FLAG_EN is defined.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*CTRL_W-1:0] op_i;
  logic [NUM_REQ*ALU_W-1:0]  a_i;
  logic [NUM_REQ*ALU_W-1:0]  b_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      busy_o;

  logic [ALU_W-1:0]          alu_data0_o;
  logic [ALU_W-1:0]          alu_data1_o;
  logic [CTRL_W-1:0]         alu_ctrl_o;
  logic [ALU_W-1:0]          alu_result_i;

  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [ID_W-1:0]           rsp_id_o;
  logic [ALU_W-1:0]          rsp_result_o;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic                      rsp_zero_o;
`endif

  modport master (
    input  req_i,
    input  op_i,
    input  a_i,
    input  b_i,
    input  alu_result_i,
    input  rsp_ready_i,
    output gnt_o,
    output busy_o,
    output alu_data0_o,
    output alu_data1_o,
    output alu_ctrl_o,
    output rsp_valid_o,
    output rsp_id_o,
    output rsp_result_o
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output rsp_zero_o
`endif
  );

  modport slave (
    output req_i,
    output op_i,
    output a_i,
    output b_i,
    output alu_result_i,
    output rsp_ready_i,
    input  gnt_o,
    input  busy_o,
    input  alu_data0_o,
    input  alu_data1_o,
    input  alu_ctrl_o,
    input  rsp_valid_o,
    input  rsp_id_o,
    input  rsp_result_o
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    input  rsp_zero_o
`endif
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first request above ptr, wrapping.
// Returns one-hot winner, its index and an any-request flag.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int               s;
  logic [ID_W-1:0]  k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = 0;
    k   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      s = int'(ptr) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      k = ID_W'(s);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU; one op in flight, tagged result out.
// Define ALU_ARB_ZERO_FLAG_EN to add the registered rsp_zero_o flag.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.master arb
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

  arb_state_t         state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    id_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [CTRL_W-1:0]  op_q;
  logic [ALU_W-1:0]   a_q;
  logic [ALU_W-1:0]   b_q;
  logic               vld_q;
  logic [ID_W-1:0]    rid_q;
  logic [ALU_W-1:0]   res_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic               zero_q;
`endif

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic [CTRL_W-1:0]  win_op;
  logic [ALU_W-1:0]   win_a;
  logic [ALU_W-1:0]   win_b;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (arb.req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // One-hot AND-OR select of the winner's operands
  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) begin
        win_op = arb.op_i[k*CTRL_W +: CTRL_W];
        win_a  = arb.a_i[k*ALU_W +: ALU_W];
        win_b  = arb.b_i[k*ALU_W +: ALU_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      ptr    <= PTR_RST;
      cnt    <= '0;
      id_q   <= '0;
      gnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      vld_q  <= 1'b0;
      rid_q  <= '0;
      res_q  <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
      zero_q <= 1'b0;
`endif
    end else begin
      gnt_q <= '0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_q <= pick_gnt;
            op_q  <= win_op;
            a_q   <= win_a;
            b_q   <= win_b;
            id_q  <= pick_idx;
            ptr   <= pick_idx;
            cnt   <= LAT_M1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            res_q  <= arb.alu_result_i;
            rid_q  <= id_q;
            vld_q  <= 1'b1;
`ifdef ALU_ARB_ZERO_FLAG_EN
            zero_q <= (arb.alu_result_i == '0);
`endif
            state  <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (vld_q && arb.rsp_ready_i) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.gnt_o        = gnt_q;
  assign arb.busy_o       = (state != IDLE);
  assign arb.alu_data0_o  = a_q;
  assign arb.alu_data1_o  = b_q;
  assign arb.alu_ctrl_o   = op_q;
  assign arb.rsp_valid_o  = vld_q;
  assign arb.rsp_id_o     = rid_q;
  assign arb.rsp_result_o = res_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
  assign arb.rsp_zero_o   = zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: two arbiters (ALU_LAT 1 and 3) each with a stub adder ALU.
// Zero-flag checks compile in with ALU_ARB_ZERO_FLAG_EN.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(4), .ID_W(2)) i1 ();
  alu_arbiter_if #(.NUM_REQ(4), .ID_W(2)) i3 ();

  assign i1.alu_result_i = i1.alu_data0_o + i1.alu_data1_o + {5'b0, i1.alu_ctrl_o};
  assign i3.alu_result_i = i3.alu_data0_o + i3.alu_data1_o + {5'b0, i3.alu_ctrl_o};

  alu_arbiter #(.NUM_REQ(4), .ALU_LAT(1), .ID_W(2)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .arb   (i1)
  );

  alu_arbiter #(.NUM_REQ(4), .ALU_LAT(3), .ID_W(2)) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .arb   (i3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (i1.gnt_o !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", i1.gnt_o); end
    checks++; if (i1.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", i1.busy_o); end
    checks++; if (i1.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", i1.rsp_valid_o); end
    checks++; if (i1.rsp_id_o !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", i1.rsp_id_o); end
    checks++; if (i1.rsp_result_o !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", i1.rsp_result_o); end
    checks++; if ({i1.alu_data0_o, i1.alu_data1_o, i1.alu_ctrl_o} !== 19'd0) begin errors++; $display("FAIL reset_alu got %h/%h/%h want 0", i1.alu_data0_o, i1.alu_data1_o, i1.alu_ctrl_o); end
    checks++; if ({i3.gnt_o, i3.busy_o, i3.rsp_valid_o} !== 6'd0) begin errors++; $display("FAIL reset_lat3 got %b/%b/%b want 0", i3.gnt_o, i3.busy_o, i3.rsp_valid_o); end
`ifdef ALU_ARB_ZERO_FLAG_EN
    checks++; if (i3.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", i3.rsp_zero_o); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    i1.a_i = 32'h0000_0006;
    i1.b_i = 32'h0000_0002;
    i1.op_i = 12'h000;
    i1.rsp_ready_i = 1'b1;
    i1.req_i = 4'b0001;
    step();
    checks++; if (i1.gnt_o !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", i1.gnt_o); end
    checks++; if (i1.busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", i1.busy_o); end
    checks++; if (i1.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", i1.rsp_valid_o); end
    i1.req_i = 4'b0000;
    step();
    checks++; if (i1.gnt_o !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse got %b want 0000", i1.gnt_o); end
    checks++; if (i1.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", i1.rsp_valid_o); end
    checks++; if (i1.rsp_id_o !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", i1.rsp_id_o); end
    checks++; if (i1.rsp_result_o !== 8'h08) begin errors++; $display("FAIL single_result got %h want 08", i1.rsp_result_o); end
    checks++; if (i1.alu_data0_o !== 8'h06) begin errors++; $display("FAIL single_alu_d0 got %h want 06", i1.alu_data0_o); end
    step();
    checks++; if ({i1.rsp_valid_o, i1.busy_o} !== 2'b00) begin errors++; $display("FAIL single_done got v=%b b=%b want 0/0", i1.rsp_valid_o, i1.busy_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] gq[$];
    int         tq[$];
    logic [1:0] iq[$];
    logic [7:0] rq[$];
    logic [3:0] exp_g [5];
    logic [7:0] exp_r [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{8'h10, 8'h22, 8'h34, 8'h46};
    rst = 1'b1;
    step();
    rst = 1'b0;
    i1.a_i = {8'h40, 8'h30, 8'h20, 8'h10};
    i1.b_i = {8'd3, 8'd2, 8'd1, 8'd0};
    i1.op_i = {3'd3, 3'd2, 3'd1, 3'd0};
    i1.rsp_ready_i = 1'b1;
    i1.req_i = 4'b1111;
    for (int c = 0; c < 60; c++) begin
      step();
      if (i1.gnt_o != 4'b0) begin
        gq.push_back(i1.gnt_o);
        tq.push_back(c);
        if (gq.size() == 5) i1.req_i = 4'b0000;
      end
      if (i1.rsp_valid_o) begin
        iq.push_back(i1.rsp_id_o);
        rq.push_back(i1.rsp_result_o);
      end
      if (gq.size() >= 5 && iq.size() >= 5) break;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= gq.size() || gq[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got %b want %b", i, (i < gq.size()) ? gq[i] : 4'bxxxx, exp_g[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (i >= tq.size() || tq[i] - tq[i-1] != 3) begin
        errors++;
        $display("FAIL rr_spacing[%0d] got %0d want 3", i, (i < tq.size()) ? tq[i] - tq[i-1] : -1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= iq.size() || iq[i] !== 2'(i % 4) || rq[i] !== exp_r[i % 4]) begin
        errors++;
        $display("FAIL rr_rsp[%0d] got id=%0d res=%h want id=%0d res=%h", i,
                 (i < iq.size()) ? iq[i] : 2'bxx, (i < rq.size()) ? rq[i] : 8'hxx, i % 4, exp_r[i % 4]);
      end
    end
    for (int c = 0; c < 10 && i1.busy_o; c++) step();
    checks++; if (i1.busy_o !== 1'b0) begin errors++; $display("FAIL rr_drain got busy=%b want 0", i1.busy_o); end
  endtask

  task automatic test_backpressure();
    i1.rsp_ready_i = 1'b0;
    i1.req_i = 4'b0100;
    for (int c = 0; c < 10 && i1.gnt_o == 4'b0; c++) step();
    checks++; if (i1.gnt_o !== 4'b0100) begin errors++; $display("FAIL bp_gnt got %b want 0100", i1.gnt_o); end
    i1.req_i = 4'b1111;
    for (int c = 0; c < 10 && !i1.rsp_valid_o; c++) step();
    checks++; if (i1.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b want 1", i1.rsp_valid_o); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (i1.rsp_valid_o !== 1'b1 || i1.rsp_id_o !== 2'd2 || i1.rsp_result_o !== 8'h34 || i1.gnt_o !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b id=%0d res=%h gnt=%b want 1/2/34/0000",
                 c, i1.rsp_valid_o, i1.rsp_id_o, i1.rsp_result_o, i1.gnt_o);
      end
    end
    i1.rsp_ready_i = 1'b1;
    step();
    checks++; if ({i1.rsp_valid_o, i1.gnt_o} !== 5'b0) begin errors++; $display("FAIL bp_handshake got v=%b gnt=%b want 0/0000", i1.rsp_valid_o, i1.gnt_o); end
    step();
    checks++; if (i1.gnt_o !== 4'b1000) begin errors++; $display("FAIL bp_next_gnt got %b want 1000", i1.gnt_o); end
    i1.req_i = 4'b0000;
    for (int c = 0; c < 10 && i1.busy_o; c++) step();
    checks++; if (i1.busy_o !== 1'b0) begin errors++; $display("FAIL bp_drain got busy=%b want 0", i1.busy_o); end
  endtask

  task automatic test_wrap_lat3();
    int n;
    i3.rsp_ready_i = 1'b1;
    i3.a_i = 32'h0000_00FF;
    i3.b_i = 32'h0000_0002;
    i3.op_i = 12'h001;
    i3.req_i = 4'b0001;
    for (int c = 0; c < 10 && i3.gnt_o == 4'b0; c++) step();
    checks++; if (i3.gnt_o !== 4'b0001) begin errors++; $display("FAIL lat3_gnt got %b want 0001", i3.gnt_o); end
    i3.req_i = 4'b0000;
    n = 0;
    for (int c = 0; c < 10 && !i3.rsp_valid_o; c++) begin
      step();
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL lat3_latency got %0d want 3", n); end
    checks++; if (i3.rsp_result_o !== 8'h02) begin errors++; $display("FAIL lat3_result got %h want 02", i3.rsp_result_o); end
    checks++; if (i3.rsp_id_o !== 2'd0) begin errors++; $display("FAIL lat3_id got %0d want 0", i3.rsp_id_o); end
`ifdef ALU_ARB_ZERO_FLAG_EN
    checks++; if (i3.rsp_zero_o !== 1'b0) begin errors++; $display("FAIL lat3_zero_clr got %b want 0", i3.rsp_zero_o); end
`endif
    step();
    checks++; if (i3.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL lat3_hs got %b want 0", i3.rsp_valid_o); end
`ifdef ALU_ARB_ZERO_FLAG_EN
    i3.a_i = 32'h0000_00FE;
    i3.b_i = 32'h0000_0001;
    i3.op_i = 12'h001;
    i3.req_i = 4'b0001;
    for (int c = 0; c < 10 && i3.gnt_o == 4'b0; c++) step();
    i3.req_i = 4'b0000;
    for (int c = 0; c < 10 && !i3.rsp_valid_o; c++) step();
    checks++; if (i3.rsp_result_o !== 8'h00) begin errors++; $display("FAIL zero_result got %h want 00", i3.rsp_result_o); end
    checks++; if (i3.rsp_zero_o !== 1'b1) begin errors++; $display("FAIL zero_flag got %b want 1", i3.rsp_zero_o); end
    step();
`endif
  endtask

  task automatic test_reset_midop();
    i1.rsp_ready_i = 1'b1;
    i1.req_i = 4'b0010;
    for (int c = 0; c < 10 && i1.gnt_o == 4'b0; c++) step();
    checks++; if (i1.gnt_o !== 4'b0010) begin errors++; $display("FAIL mid_gnt got %b want 0010", i1.gnt_o); end
    rst = 1'b1;
    step();
    checks++; if ({i1.busy_o, i1.rsp_valid_o, i1.gnt_o} !== 6'd0) begin errors++; $display("FAIL mid_abort got b=%b v=%b gnt=%b want 0", i1.busy_o, i1.rsp_valid_o, i1.gnt_o); end
    checks++; if ({i1.rsp_result_o, i1.alu_data0_o} !== 16'd0) begin errors++; $display("FAIL mid_clear got res=%h d0=%h want 00/00", i1.rsp_result_o, i1.alu_data0_o); end
    rst = 1'b0;
    i1.req_i = 4'b1111;
    step();
    checks++; if (i1.gnt_o !== 4'b0001) begin errors++; $display("FAIL mid_first_gnt got %b want 0001", i1.gnt_o); end
    i1.req_i = 4'b0000;
    for (int c = 0; c < 10 && i1.busy_o; c++) step();
  endtask

  initial begin
    i1.req_i = '0; i1.op_i = '0; i1.a_i = '0; i1.b_i = '0; i1.rsp_ready_i = 1'b0;
    i3.req_i = '0; i3.op_i = '0; i3.a_i = '0; i3.b_i = '0; i3.rsp_ready_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_lat3();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
